// File: rtl/get_seq_pkg.sv
// get_seq_pkg -- shared definitions for the get sequencer.
//   gs_state_e : sequencer FSM state encoding
//   DRAIN_LEN  : cycles spent in DRAIN after the pass ends; this covers the
//                one-cycle exec register inside get_ctrl
//   DRAIN_CW   : width of the DRAIN cycle counter
package get_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gs_state_e;

  localparam int unsigned DRAIN_LEN = 2;
  localparam int unsigned DRAIN_CW  = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

endpackage

// File: rtl/get_seq.sv
// get_seq -- sequences one get pass through get_ctrl.
//
// A command latches the i/j bounds and requests a pass. While the pass runs,
// the block counts exec strobes and runs a watchdog. The pass ends on
// get_fin or on watchdog expiry, drains for DRAIN_LEN cycles, and then
// pulses done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_v / cmd_ready   command handshake; ready only in IDLE
//   cmd_i, cmd_j        outer/inner bounds for the pass
//   tmo_lim             watchdog limit in RUN cycles, 0 = disabled
//   get_v               level request to get_ctrl, high for every RUN cycle
//   addr_i, addr_j      latched bounds driven to get_ctrl
//   exec, get_fin       execute strobe and pass-complete strobe from get_ctrl
//   busy, done, err     status: not idle, completion pulse, watchdog expiry
//   exec_cnt            saturating count of exec cycles in RUN/DRAIN
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// RUN   | get_v high, counting exec, watchdog running
// DRAIN | DRAIN_LEN cycles to catch the last registered exec strobes
// DONE  | one-cycle done pulse
module get_seq #(
  parameter int W  = 20,
  parameter int TW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_v,
  output logic            cmd_ready,
  input  logic [W-1:0]    cmd_i,
  input  logic [W-1:0]    cmd_j,
  input  logic [TW-1:0]   tmo_lim,
  output logic            get_v,
  output logic [W-1:0]    addr_i,
  output logic [W-1:0]    addr_j,
  input  logic            exec,
  input  logic            get_fin,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2*W-1:0]  exec_cnt
);
  import get_seq_pkg::*;

  gs_state_e             r_state;
  logic                  r_get_v;
  logic                  r_done;
  logic                  r_err;
  logic [W-1:0]          r_addr_i;
  logic [W-1:0]          r_addr_j;
  logic [2*W-1:0]        r_exec_cnt;
  logic [TW-1:0]         r_wdog;
  logic [DRAIN_CW-1:0]   r_drain;

  logic w_accept;
  logic w_wdog_exp;
  logic w_exec_inc;

  assign w_accept   = (r_state == ST_IDLE) && cmd_v;
  // The watchdog holds the number of completed RUN cycles, so the expiry
  // compare against tmo_lim-1 fires in the tmo_lim-th RUN cycle.
  assign w_wdog_exp = (tmo_lim != '0) && (r_wdog == (tmo_lim - TW'(1)));
  assign w_exec_inc = exec && ((r_state == ST_RUN) || (r_state == ST_DRAIN))
                      && (r_exec_cnt != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_get_v    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr_i   <= '0;
      r_addr_j   <= '0;
      r_exec_cnt <= '0;
      r_wdog     <= '0;
      r_drain    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_exec_inc) r_exec_cnt <= r_exec_cnt + (2*W)'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr_i   <= cmd_i;
            r_addr_j   <= cmd_j;
            r_exec_cnt <= '0;
            r_err      <= 1'b0;
            r_wdog     <= '0;
            r_get_v    <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Saturate only matters with the watchdog disabled.
          if (r_wdog != '1) r_wdog <= r_wdog + TW'(1);
          // get_fin takes priority over a simultaneous watchdog expiry.
          if (get_fin) begin
            r_get_v <= 1'b0;
            r_drain <= '0;
            r_state <= ST_DRAIN;
          end else if (w_wdog_exp) begin
            r_err   <= 1'b1;
            r_get_v <= 1'b0;
            r_drain <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_CW'(DRAIN_LEN - 1)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_drain <= r_drain + DRAIN_CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_get_v <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign get_v     = r_get_v;
  assign done      = r_done;
  assign err       = r_err;
  assign addr_i    = r_addr_i;
  assign addr_j    = r_addr_j;
  assign exec_cnt  = r_exec_cnt;

endmodule

// File: tb/tb_get_seq.sv
// tb_get_seq -- self-checking bench for get_seq.
// The model works out each pass from the rules: the pass stops in RUN cycle S,
// which is the get_fin cycle when get_fin arrives first or ties with expiry,
// and is tmo_lim otherwise. get_v is high for cycles 1..S. exec counts in
// cycles 1..S+2. done is high in cycle S+3, and the block is idle again in S+4.
module tb_get_seq;
  localparam int W  = 20;
  localparam int TW = 24;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_v = 1'b0;
  logic           cmd_ready;
  logic [W-1:0]   cmd_i = '0;
  logic [W-1:0]   cmd_j = '0;
  logic [TW-1:0]  tmo_lim = '0;
  logic           get_v;
  logic [W-1:0]   addr_i;
  logic [W-1:0]   addr_j;
  logic           exec = 1'b0;
  logic           get_fin = 1'b0;
  logic           busy;
  logic           done;
  logic           err;
  logic [2*W-1:0] exec_cnt;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] last_cnt = '0;
  logic           last_err = 1'b0;

  get_seq #(.W(W), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_v(cmd_v), .cmd_ready(cmd_ready),
    .cmd_i(cmd_i), .cmd_j(cmd_j), .tmo_lim(tmo_lim), .get_v(get_v),
    .addr_i(addr_i), .addr_j(addr_j), .exec(exec), .get_fin(get_fin),
    .busy(busy), .done(done), .err(err), .exec_cnt(exec_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Call this right after a falling edge while the block is idle.
  task automatic run_pass(input logic [W-1:0] ci, input logic [W-1:0] cj,
                          input logic [TW-1:0] lim, input int fin_at, input bit hold);
    int s;
    bit fin_ok;
    bit err_e;
    bit e;
    logic [2*W-1:0] cnt_e;
    fin_ok = (fin_at > 0) && ((lim == '0) || (fin_at <= int'(lim)));
    s      = fin_ok ? fin_at : int'(lim);
    err_e  = !fin_ok;
    cnt_e  = '0;
    chk("ready_before_accept", cmd_ready, 1);
    cmd_v   = 1'b1;
    cmd_i   = ci;
    cmd_j   = cj;
    tmo_lim = lim;
    get_fin = 1'b0;
    exec    = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int c = 1; c <= s + 4; c++) begin
      @(negedge clk);
      chk("get_v", get_v, (c <= s));
      chk("busy", busy, (c <= s + 3));
      chk("done", done, (c == s + 3));
      chk("cmd_ready", cmd_ready, (c >= s + 4));
      chk("err", err, (c > s) ? err_e : 1'b0);
      chk("exec_cnt", exec_cnt, cnt_e);
      chk("addr_i", addr_i, ci);
      chk("addr_j", addr_j, cj);
      if (c < s + 4) begin
        cmd_v   = hold;
        cmd_i   = W'($urandom);
        cmd_j   = W'($urandom);
        e       = 1'($urandom_range(0, 1));
        exec    = e;
        if (e && (c <= s + 2)) cnt_e = cnt_e + 1'b1;
        get_fin = (c == fin_at);
      end
    end
    last_cnt = cnt_e;
    last_err = err_e;
  endtask

  initial begin
    logic [TW-1:0] lim;
    int fin;

    // Reset state.
    #12;
    chk("rst_get_v", get_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_exec_cnt", exec_cnt, 0);
    chk("rst_addr_i", addr_i, 0);
    chk("rst_addr_j", addr_j, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Accept on the first edge after reset release; get_ctrl finishes
    // after (i+1)*(j+1) = 6 cycles.
    run_pass(W'(1), W'(2), '0, 6, 1'b0);
    // Watchdog expiry with no get_fin.
    run_pass(W'(7), W'(9), TW'(5), 0, 1'b0);
    // get_fin on the expiry cycle wins.
    run_pass(W'(3), W'(4), TW'(4), 4, 1'b0);
    // Earliest possible expiry.
    run_pass(W'(5), W'(6), TW'(1), 0, 1'b0);

    // cmd_v held high across two passes.
    run_pass(W'(11), W'(12), TW'(3), 2, 1'b1);
    run_pass(W'(13), W'(14), '0, 3, 1'b1);
    cmd_v = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_third_accept", busy, 0);
    end

    // Stray get_fin and exec while idle.
    get_fin = 1'b1;
    exec    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_get_v", get_v, 0);
      chk("stray_exec_cnt", exec_cnt, last_cnt);
      chk("stray_err", err, last_err);
    end
    get_fin = 1'b0;
    exec    = 1'b0;

    // Reset in the middle of RUN.
    cmd_v   = 1'b1;
    cmd_i   = W'(21);
    cmd_j   = W'(22);
    tmo_lim = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0;
    exec  = 1'b1;
    @(negedge clk);
    chk("pre_rst_get_v", get_v, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_get_v", get_v, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_exec_cnt", exec_cnt, 0);
    chk("mid_rst_addr_i", addr_i, 0);
    exec = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_pass(W'(31), W'(32), TW'(6), 3, 1'b0);

    // Randomized passes.
    for (int k = 0; k < 12; k++) begin
      lim = TW'($urandom_range(0, 8));
      fin = int'($urandom_range(0, 10));
      if ((lim == '0) && (fin == 0)) fin = 1 + int'($urandom_range(0, 9));
      run_pass(W'($urandom), W'($urandom), lim, fin, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/get_seq.md
GET_SEQ -- requirements
Module: get_seq

Interface
REQ-001 Parameter W, default 20, width of the i/j bound fields passed to get_ctrl.
REQ-002 Parameter TW, default 24, width of the watchdog cycle counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_v  input  1  command valid from host/register block.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_i  input  W  outer bound (last i index) for the get pass.
REQ-008 cmd_j  input  W  inner bound (last j index) for the get pass.
REQ-009 tmo_lim  input  TW  watchdog limit in cycles; 0 disables the watchdog.
REQ-010 get_v  output  1  level request to get_ctrl; high for the whole pass.
REQ-011 addr_i  output  W  latched cmd_i, driven to get_ctrl.
REQ-012 addr_j  output  W  latched cmd_j, driven to get_ctrl.
REQ-013 exec  input  1  per-cycle execute strobe from get_ctrl.
REQ-014 get_fin  input  1  pass-complete strobe from get_ctrl.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  status of last pass: 1 = watchdog expiry; valid from done until next accept.
REQ-018 exec_cnt  output  2W  number of exec-high cycles seen in the last/current pass.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE.
REQ-020 cmd_ready = 1 only in IDLE; command accepted when cmd_v & cmd_ready on a rising edge.
REQ-021 On accept: latch cmd_i/cmd_j into addr_i/addr_j, clear exec_cnt, err and watchdog counter, go to RUN.
REQ-022 addr_i/addr_j hold stable from accept until the next accept.
REQ-023 get_v is registered: 1 in every RUN cycle, 0 otherwise; first get_v cycle is the cycle after accept.
REQ-024 In RUN/DRAIN, each cycle with exec = 1 increments exec_cnt by 1, saturating at all-ones.
REQ-025 RUN: get_fin = 1 -> DRAIN; get_v falls the next cycle.
REQ-026 RUN: tmo_lim != 0 and watchdog count == tmo_lim - 1 with get_fin = 0 -> set err, go to DRAIN.
REQ-027 Watchdog counts RUN cycles only; it cleared on accept; width TW, no wrap (expiry precedes wrap).
REQ-028 get_fin and watchdog expiry in the same cycle: get_fin wins, err stays 0.
REQ-029 DRAIN lasts exactly 2 cycles (covers the 1-cycle exec register in get_ctrl), then DONE.
REQ-030 DONE lasts 1 cycle with done = 1, then IDLE.
REQ-031 get_fin or exec in IDLE/DONE is ignored; exec_cnt unchanged.
REQ-032 cmd_v while busy is ignored; it is not queued.
REQ-033 Accept to done latency with get_fin first seen in cycle N of RUN: N + 3 cycles after the RUN entry edge.

Reset
REQ-034 rst_n low asynchronously forces IDLE, get_v = 0, done = 0, err = 0, busy = 0, exec_cnt = 0, addr_i = addr_j = 0, watchdog = 0.
REQ-035 Reset during RUN aborts the pass without a done pulse; get_v is 0 immediately.
REQ-036 First accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-037 FSM state enum and the DRAIN length constant (2) live in the shared HPU package.
REQ-038 Single flat module, no sub-modules; the watchdog is an inline counter.

Verification
REQ-039 cmd_i = 1, cmd_j = 2 against a get_ctrl model -> get_v high until get_fin; done pulses once; err = 0; exec_cnt = number of exec cycles the model drives.
REQ-040 tmo_lim = 5, model never raises get_fin -> get_v high 5 cycles; err = 1; done pulses 3 cycles after the last get_v cycle.
REQ-041 get_fin on the same cycle as watchdog expiry (tmo_lim = 4, get_fin in 4th RUN cycle) -> err = 0, done pulses.
REQ-042 cmd_v held high throughout two passes -> exactly two accepts, one per IDLE; cmd_i changed mid-pass does not alter addr_i.
REQ-043 rst_n pulsed low mid-RUN -> get_v, busy = 0 asynchronously; no done; next command proceeds normally.
REQ-044 Stray get_fin and exec in IDLE -> no state change, exec_cnt unchanged.
